// File: rtl/aximm_mem_responder_if.sv
// AXI4 memory-mapped bus bundle between a CGRA master and aximm_mem_responder.
// Carries the AR/R/AW/W/B channels; the slave modport is the responder's view.
interface aximm_mem_responder_if #(
    parameter int unsigned phit_size    = 512,
    parameter int unsigned dwidth_aximm = 64
);
    logic [dwidth_aximm-1:0] araddr;
    logic [7:0]              arlen;
    logic                    arvalid;
    logic                    arready;
    logic [phit_size-1:0]    rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;
    logic [dwidth_aximm-1:0] awaddr;
    logic [7:0]              awlen;
    logic                    awvalid;
    logic                    awready;
    logic [phit_size-1:0]    wdata;
    logic [phit_size/8-1:0]  wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport slave (
        input  araddr, arlen, arvalid, rready,
        input  awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        output arready, rdata, rresp, rlast, rvalid,
        output awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arlen, arvalid, rready,
        output awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
        input  arready, rdata, rresp, rlast, rvalid,
        input  awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/aximm_mem_responder.sv
// BRAM-backed AXI4 MM slave: INCR bursts up to 256 beats, one transaction at a time.
// Optional AXIMM_RESP_RANGE_CHECK_EN turns out-of-range bursts into SLVERR bursts.
module aximm_mem_responder #(
    parameter int unsigned phit_size      = 512,
    parameter int unsigned dwidth_aximm   = 64,
    parameter int unsigned mem_depth_log2 = 10
) (
    input logic                  clk,
    input logic                  rst,
    aximm_mem_responder_if.slave s_axi
);
    localparam int unsigned BYTES = phit_size / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned DEPTH = 1 << mem_depth_log2;

    typedef logic [mem_depth_log2-1:0] idx_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    state_t      state_q, state_d;
    idx_t        idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        wr_err_q, wr_err_d;
    logic        rng_err_q, rng_err_d;
    logic        rvalid_q, rvalid_d;
    logic        rlast_q, rlast_d;
    logic        mem_re, mem_we;
    logic        ar_rng_err, aw_rng_err;

    logic [phit_size-1:0] mem [DEPTH];
    logic [phit_size-1:0] mem_dout_q;

`ifdef AXIMM_RESP_RANGE_CHECK_EN
    logic [31:0] ar_end, aw_end;
    always_comb begin
        ar_end     = 32'(s_axi.araddr[LSB +: mem_depth_log2]) + 32'(s_axi.arlen);
        aw_end     = 32'(s_axi.awaddr[LSB +: mem_depth_log2]) + 32'(s_axi.awlen);
        ar_rng_err = (ar_end >= 32'(DEPTH)) || ((s_axi.araddr >> (LSB + mem_depth_log2)) != '0);
        aw_rng_err = (aw_end >= 32'(DEPTH)) || ((s_axi.awaddr >> (LSB + mem_depth_log2)) != '0);
    end
`else
    always_comb begin
        ar_rng_err = 1'b0;
        aw_rng_err = 1'b0;
    end
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        wr_err_d  = wr_err_q;
        rng_err_d = rng_err_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_axi.awvalid) begin
                    state_d   = WR_DATA;
                    idx_d     = s_axi.awaddr[LSB +: mem_depth_log2];
                    cnt_d     = s_axi.awlen;
                    wr_err_d  = 1'b0;
                    rng_err_d = aw_rng_err;
                end else if (s_axi.arvalid) begin
                    state_d   = RD_FETCH;
                    idx_d     = s_axi.araddr[LSB +: mem_depth_log2];
                    cnt_d     = s_axi.arlen;
                    rng_err_d = ar_rng_err;
                end
            end
            RD_FETCH: begin
                mem_re   = 1'b1;
                idx_d    = idx_q + 1'b1;
                cnt_d    = cnt_q - 8'd1;
                rlast_d  = (cnt_q == 8'd0);
                rvalid_d = 1'b1;
                state_d  = RD_DATA;
            end
            RD_DATA: begin
                // The BRAM output register only advances on a handshake, so it
                // doubles as the holding register while the master stalls.
                if (s_axi.rready) begin
                    if (rlast_q) begin
                        state_d  = IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        mem_re  = 1'b1;
                        idx_d   = idx_q + 1'b1;
                        cnt_d   = cnt_q - 8'd1;
                        rlast_d = (cnt_q == 8'd0);
                    end
                end
            end
            WR_DATA: begin
                if (s_axi.wvalid) begin
                    mem_we = !rng_err_q;
                    idx_d  = idx_q + 1'b1;
                    cnt_d  = cnt_q - 8'd1;
                    if (s_axi.wlast != (cnt_q == 8'd0)) begin
                        wr_err_d = 1'b1;
                    end
                    if (cnt_q == 8'd0) begin
                        state_d = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (s_axi.bready) begin
                    state_d   = IDLE;
                    wr_err_d  = 1'b0;
                    rng_err_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            wr_err_q  <= 1'b0;
            rng_err_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            wr_err_q  <= wr_err_d;
            rng_err_q <= rng_err_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    // Backing store keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (s_axi.wstrb[b]) begin
                    mem[idx_q][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
                end
            end
        end
        if (mem_re) begin
            mem_dout_q <= mem[idx_q];
        end
    end

    // Ready/valid are gated by rst so every output drops as soon as reset rises.
    assign s_axi.awready = !rst && (state_q == IDLE);
    assign s_axi.arready = !rst && (state_q == IDLE) && !s_axi.awvalid;
    assign s_axi.wready  = (state_q == WR_DATA);
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rlast   = rlast_q;
    assign s_axi.rresp   = (rvalid_q && rng_err_q) ? 2'b10 : 2'b00;
    assign s_axi.rdata   = (rvalid_q && !rng_err_q) ? mem_dout_q : '0;
    assign s_axi.bvalid  = (state_q == WR_RESP);
    assign s_axi.bresp   = ((state_q == WR_RESP) && (wr_err_q || rng_err_q)) ? 2'b10 : 2'b00;
endmodule
